uart_rx_unit: RTL and testbench



---
 rtl/uart_rx_unit.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_unit.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// The line is synchronised, a falling edge starts a frame, and every bit is sampled at mid-bit.
module uart_rx_unit #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        rxd,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    input  logic        rdata_ready
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLK_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic           sync1_r;
    logic           sync2_r;
    logic           hist_r;
    logic [CW-1:0]  cnt_r;
    logic [2:0]     bit_r;
    logic [7:0]     shift_r;

    logic           fall_s;
    logic           half_tick_s;
    logic           full_tick_s;
    logic           cnt_clr_s;
    logic           bit_clr_s;
    logic           shift_en_s;
    logic           good_stop_s;
    logic           consume_s;
    logic           load_s;

    assign fall_s      = hist_r & ~sync2_r;
    assign half_tick_s = (cnt_r == HALF_LAST);
    assign full_tick_s = (cnt_r == FULL_LAST);
    assign consume_s   = rdata_valid & rdata_ready;
    assign load_s      = good_stop_s & (~rdata_valid | rdata_ready);

    // Synchroniser and history flops; reset low so a held-low line never looks like a start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= rxd;
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (fall_s) state_s = S_START;
                else        state_s = S_IDLE;
            end
            S_START: begin
                if (half_tick_s) state_s = sync2_r ? S_IDLE : S_DATA;
                else             state_s = S_START;
            end
            S_DATA: begin
                if (full_tick_s && (bit_r == 3'd7)) state_s = S_STOP;
                else                                 state_s = S_DATA;
            end
            S_STOP: begin
                if (full_tick_s) state_s = sync2_r ? S_IDLE : S_BREAK;
                else             state_s = S_STOP;
            end
            S_BREAK: begin
                if (sync2_r) state_s = S_IDLE;
                else         state_s = S_BREAK;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM control strobes for the counters, shifter and buffer.
    always_comb begin
        cnt_clr_s   = 1'b0;
        bit_clr_s   = 1'b0;
        shift_en_s  = 1'b0;
        good_stop_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_clr_s = 1'b1;
                bit_clr_s = 1'b1;
            end
            S_START: begin
                cnt_clr_s = half_tick_s;
            end
            S_DATA: begin
                cnt_clr_s  = full_tick_s;
                shift_en_s = full_tick_s;
            end
            S_STOP: begin
                cnt_clr_s   = full_tick_s;
                good_stop_s = full_tick_s & sync2_r;
            end
            S_BREAK: begin
                cnt_clr_s = 1'b1;
            end
            default: begin
                cnt_clr_s = 1'b1;
                bit_clr_s = 1'b1;
            end
        endcase
    end

    // Bit-period counter, data bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r   <= {CW{1'b0}};
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            if (cnt_clr_s) cnt_r <= {CW{1'b0}};
            else           cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (bit_clr_s)       bit_r <= 3'd0;
            else if (shift_en_s) bit_r <= bit_r + 3'd1;
            else                 bit_r <= bit_r;
            if (shift_en_s) shift_r <= {sync2_r, shift_r[7:1]};
            else            shift_r <= shift_r;
        end
    end

    // One-entry output buffer: a new byte may replace one consumed at the same edge, else it is dropped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata       <= 32'h0000_0000;
            rdata_valid <= 1'b0;
        end else if (load_s) begin
            rdata       <= {24'h00_0000, shift_r};
            rdata_valid <= 1'b1;
        end else if (consume_s) begin
            rdata       <= rdata;
            rdata_valid <= 1'b0;
        end else begin
            rdata       <= rdata;
            rdata_valid <= rdata_valid;
        end
    end

endmodule

// File: tb/tb_uart_rx_unit.sv
// Scoreboard bench for uart_rx_unit: directed frames push expected bytes,
// a monitor pops and compares at every accepted handshake.
module tb_uart_rx_unit;

    localparam int CPB     = 16;
    localparam int FRAME   = 10 * CPB;
    localparam int LAT_NOM = CPB / 2 + 9 * CPB + 3;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b0;
    logic        rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          c0;
    int          lat;
    logic [7:0]  exp_q[$];
    logic [7:0]  mon_exp;

    uart_rx_unit #(.CLK_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rxd         (rxd),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must be the oldest expected one.
    always @(negedge clk) begin
        if (rstn && rdata_valid && rdata_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %h, scoreboard empty", rdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rdata !== {24'h0, mon_exp}) begin
                    errors++;
                    $display("FAIL sb_byte: got %h, expected %h", rdata, {24'h0, mon_exp});
                end
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rxd = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rxd = stop;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_ready();
        rdata_ready = 1'b1;
        @(posedge clk);
        #1 rdata_ready = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int l);
        bit found;
        found = 1'b0;
        l = LAT_NOM;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            @(negedge clk);
            if (rdata_valid) begin
                found = 1'b1;
                l = cyc - start;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL valid_timeout: got no rdata_valid, expected one within %0d cycles", 2 * FRAME);
        end
    endtask

    task automatic watch_low(input int n, input string name);
        int bad;
        bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (rdata_valid) bad++;
        end
        @(posedge clk);
        #1;
        chk(name, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected one before 500000 ns");
        $fatal(1);
    end

    initial begin
        int bad;
        // Reset with the line held low, then released while still low.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_valid", rdata_valid, 0);
        rstn = 1'b1;
        watch_low(20 * CPB, "reset_line_low");
        rxd = 1'b1;
        watch_low(4 * CPB, "reset_line_idle");
        chk("reset_rdata_after", rdata, 32'h0);

        // Single byte with latency measurement.
        exp_q.push_back(8'hA5);
        c0 = cyc;
        fork
            send_frame(8'hA5, 1'b1);
            wait_valid(c0, lat);
        join
        chk("latency_in_range", (lat >= LAT_NOM - 1) && (lat <= LAT_NOM + 1), 1);
        chk("single_rdata", rdata, 32'h0000_00A5);
        chk("single_valid", rdata_valid, 1);
        pulse_ready();
        chk("single_consumed", rdata_valid, 0);

        // Back-to-back frames, each consume lands on the edge the next byte loads.
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h3C);
        c0 = cyc;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h3C, 1'b1);
            end
            begin
                wait_cyc(c0 + FRAME + lat - 1);
                pulse_ready();
                wait_cyc(c0 + 2 * FRAME + lat - 1);
                pulse_ready();
            end
            begin
                wait_cyc(c0 + lat);
                bad = 0;
                repeat (2 * FRAME + 4) begin
                    @(negedge clk);
                    if (!rdata_valid) bad++;
                end
                chk("b2b_valid_held", bad, 0);
            end
        join
        chk("b2b_last_rdata", rdata, 32'h0000_003C);
        pulse_ready();
        chk("b2b_consumed", rdata_valid, 0);

        // Overrun: second byte arrives while the first is still unread.
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle_bits(2);
        chk("overrun_rdata", rdata, 32'h0000_0011);
        chk("overrun_valid", rdata_valid, 1);
        pulse_ready();
        watch_low(12 * CPB, "overrun_no_more");

        // Framing error, line held low (break), then a good frame.
        send_frame(8'h55, 1'b0);
        watch_low(2 * CPB, "framing_break_low");
        rxd = 1'b1;
        idle_bits(2);
        exp_q.push_back(8'h81);
        c0 = cyc;
        fork
            send_frame(8'h81, 1'b1);
            wait_valid(c0, lat);
        join
        chk("framing_next_rdata", rdata, 32'h0000_0081);
        pulse_ready();

        // Short low glitch.
        rxd = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1 rxd = 1'b1;
        watch_low(12 * CPB, "glitch_no_output");

        // Reset during data bit 4; remaining bits are all ones so no new start appears.
        c0 = cyc;
        fork
            send_frame(8'hF3, 1'b1);
            begin
                wait_cyc(c0 + 5 * CPB + CPB / 2);
                rstn = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                chk("midreset_rdata", rdata, 32'h0);
                chk("midreset_valid", rdata_valid, 0);
                rstn = 1'b1;
            end
        join
        watch_low(4 * CPB, "midreset_no_output");
        exp_q.push_back(8'h5A);
        c0 = cyc;
        fork
            send_frame(8'h5A, 1'b1);
            wait_valid(c0, lat);
        join
        chk("midreset_next_rdata", rdata, 32'h0000_005A);
        pulse_ready();
        idle_bits(1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
